// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-subset control FSM (Moore, registered illegal pulse).
// Define MC_CONTROL_MUL_EN to add the mul instruction with its MUL_WAIT countdown.
module mc_control #(
  parameter int MULT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_select,
  output logic       illegal,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP
`ifdef MC_CONTROL_MUL_EN
    , MUL_WAIT
`endif
  } state_t;
  state_t cur, nxt;
  logic bad_nxt, mul_op, r_ok, pcw, irw, mr, mw, rw;
  logic [3:0] r_code, i_code;
  if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_cycles
    $error("MULT_CYCLES must be 1..15");
  end
`ifdef MC_CONTROL_MUL_EN
  logic [3:0] cnt;
  assign mul_op = opcode == 6'b011100 && funct == 6'b000010;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (cur == R_EXEC) cnt <= 4'(MULT_CYCLES);
    else if (cur == MUL_WAIT) cnt <= cnt - 4'd1;
`else
  assign mul_op = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur     <= FETCH;
      illegal <= 1'b0;
    end else begin
      cur     <= nxt;
      illegal <= bad_nxt;
    end
  // The IR is stable across an instruction, so R_WB re-decodes funct to hold the executed code.
  always_comb begin
    r_ok   = 1'b1;
    r_code = 4'b0000;
    case (funct)
      6'b100000: r_code = 4'b0000;
      6'b100010: r_code = 4'b0111;
      6'b100100: r_code = 4'b0001;
      6'b100101: r_code = 4'b0010;
      6'b100111: r_code = 4'b0011;
      6'b101010: r_code = 4'b0100;
      6'b000000: r_code = 4'b0101;
      6'b000010: r_code = 4'b0110;
      default:   r_ok   = 1'b0;
    endcase
    if (mul_op) r_code = 4'b1000;
  end
  assign i_code = opcode[2:0] == 3'b100 ? 4'b0001 :
                  opcode[2:0] == 3'b101 ? 4'b0010 :
                  opcode[2:0] == 3'b010 ? 4'b0100 :
                  opcode[2:0] == 3'b111 ? 4'b1001 : 4'b0000;
  always_comb begin
    nxt        = FETCH;
    bad_nxt    = 1'b0;
    pcw        = 1'b0;
    irw        = 1'b0;
    mr         = 1'b0;
    mw         = 1'b0;
    rw         = 1'b0;
    i_or_d     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_select = 4'b0000;
    case (cur)
      FETCH: begin
        pcw       = 1'b1;
        irw       = 1'b1;
        mr        = 1'b1;
        alu_src_b = 2'b01;
        nxt       = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == 6'b100011 || opcode == 6'b101011) nxt = MEM_ADR;
        else if (opcode == 6'b000000 || mul_op) nxt = R_EXEC;
        else if (opcode inside {6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111}) nxt = I_EXEC;
        else if (opcode == 6'b000100 || opcode == 6'b000101) nxt = BRANCH;
        else if (opcode == 6'b000010) nxt = JUMP;
        else bad_nxt = 1'b1;
      end
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = opcode[3] ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mr     = 1'b1;
        i_or_d = 1'b1;
        nxt    = MEM_WB;
      end
      MEM_WB: begin
        rw         = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mw     = 1'b1;
        i_or_d = 1'b1;
      end
      R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_select = r_code;
        bad_nxt    = !r_ok;
`ifdef MC_CONTROL_MUL_EN
        nxt = !r_ok ? FETCH : mul_op ? MUL_WAIT : R_WB;
`else
        nxt = r_ok ? R_WB : FETCH;
`endif
      end
`ifdef MC_CONTROL_MUL_EN
      MUL_WAIT: begin
        alu_select = 4'b1000;
        nxt        = cnt == 4'd1 ? R_WB : MUL_WAIT;
      end
`endif
      R_WB: begin
        rw         = 1'b1;
        reg_dst    = 1'b1;
        alu_select = r_code;
      end
      I_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_select = i_code;
        nxt        = I_WB;
      end
      I_WB: rw = 1'b1;
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_select = 4'b0111;
        pc_src     = 2'b01;
        pcw        = opcode[0] ? ~zero : zero;
      end
      JUMP: begin
        pcw    = 1'b1;
        pc_src = 2'b10;
      end
      default: ;
    endcase
  end
  // Reset holds the state at FETCH, so write enables are masked while rst_n is low.
  assign pc_write  = pcw & rst_n;
  assign ir_write  = irw & rst_n;
  assign mem_read  = mr & rst_n;
  assign mem_write = mw & rst_n;
  assign reg_write = rw & rst_n;
  assign state     = cur;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed instruction sequences checked each cycle against a per-instruction
// expected-control list, plus hand-computed literal vectors and reset checks.
module tb_mc_control;
`ifdef MC_CONTROL_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int M = 4;
  typedef logic [17:0] vec_t;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_select, state, fetch_state;
  int total = 0, bad = 0, rw_cnt = 0, rw_base, s;
  bit pend = 1'b0;
  vec_t exp_q[$], hist[$];
  string nm_q[$];
  vec_t act;

  mc_control #(.MULT_CYCLES(M)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_select(alu_select),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;
  assign act = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, pc_src, alu_select, illegal};

  always @(negedge clk) begin
    if (rst_n) begin
      hist.push_back(act);
      if (reg_write) rw_cnt++;
      if (exp_q.size() > 0) begin
        vec_t e;
        string n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        total++;
        if (act !== e) begin
          bad++;
          $display("FAIL %s cycle: got %b want %b", n, act, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic pcw, irw, mr, mw, iod, rw, rd, m2r, asa,
                              input logic [1:0] asb, pcs, input logic [3:0] alu, input logic ill);
    return {pcw, irw, mr, mw, iod, rw, rd, m2r, asa, asb, pcs, alu, ill};
  endfunction

  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 0;
      6'b100010: return 7;
      6'b100100: return 1;
      6'b100101: return 2;
      6'b100111: return 3;
      6'b101010: return 4;
      6'b000000: return 5;
      6'b000010: return 6;
      default:   return -1;
    endcase
  endfunction

  function automatic int i_alu(input logic [5:0] op);
    case (op)
      6'b001000: return 0;
      6'b001100: return 1;
      6'b001101: return 2;
      6'b001010: return 4;
      6'b001111: return 9;
      default:   return -1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Called at posedge+1 while the DUT sits in FETCH; builds the whole expected cycle list.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input string nm);
    vec_t q[$];
    int code;
    bit mulop;
    mulop = MUL_EN && op == 6'b011100 && fn == 6'b000010;
    q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'h0, pend));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 4'h0, 0));
    pend = 1'b0;
    if (op == 6'b100011 || op == 6'b101011) begin
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'h0, 0));
      if (op == 6'b100011) begin
        q.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 4'h0, 0));
      end else
        q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0));
    end else if (op == 6'b000000 || mulop) begin
      code = mulop ? 8 : r_alu(fn);
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, code < 0 ? 4'h0 : 4'(code), 0));
      if (code < 0) pend = 1'b1;
      else begin
        for (int i = 0; i < (mulop ? M : 0); i++)
          q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h8, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 4'(code), 0));
      end
    end else if (i_alu(op) >= 0) begin
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 4'(i_alu(op)), 0));
      q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0));
    end else if (op == 6'b000100 || op == 6'b000101)
      q.push_back(mk(op == 6'b000100 ? z : !z, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 4'h7, 0));
    else if (op == 6'b000010)
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 4'h0, 0));
    else pend = 1'b1;
    opcode = op;
    funct  = fn;
    zero   = z;
    foreach (q[i]) begin
      exp_q.push_back(q[i]);
      nm_q.push_back(nm);
    end
    repeat (q.size()) @(posedge clk);
    #1;
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_enables", {pc_write, ir_write, mem_read, mem_write, reg_write}, 5'b0);
    chk("rst_alu", alu_select, 4'b0000);
    chk("rst_illegal", illegal, 1'b0);
    fetch_state = state;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s = hist.size();
    run(6'b000000, 6'b100000, 1'b0, "add");
    chk("add_rexec_lit", hist[s+2], {9'b000000001, 2'b00, 2'b00, 4'b0000, 1'b0});
    chk("add_rwb_lit", hist[s+3], {9'b000001100, 2'b00, 2'b00, 4'b0000, 1'b0});
    run(6'b000000, 6'b100010, 1'b0, "sub");
    run(6'b000000, 6'b100100, 1'b0, "and");
    run(6'b000000, 6'b100101, 1'b0, "or");
    run(6'b000000, 6'b100111, 1'b0, "nor");
    run(6'b000000, 6'b101010, 1'b0, "slt");
    run(6'b000000, 6'b000000, 1'b0, "sll");
    run(6'b000000, 6'b000010, 1'b0, "srl");
    run(6'b001000, 6'b010101, 1'b0, "addi");
    run(6'b001100, 6'b000000, 1'b0, "andi");
    run(6'b001101, 6'b000000, 1'b0, "ori");
    run(6'b001010, 6'b000000, 1'b0, "slti");
    run(6'b001111, 6'b000000, 1'b0, "lui");
    s = hist.size();
    run(6'b000100, 6'b000000, 1'b1, "beq_z1");
    chk("beq_z1_lit", hist[s+2], {9'b100000001, 2'b00, 2'b01, 4'b0111, 1'b0});
    run(6'b000100, 6'b000000, 1'b0, "beq_z0");
    run(6'b000101, 6'b000000, 1'b1, "bne_z1");
    run(6'b000101, 6'b000000, 1'b0, "bne_z0");
    s = hist.size();
    run(6'b100011, 6'b000000, 1'b0, "lw");
    chk("lw_memwb_lit", hist[s+4], {9'b000001010, 2'b00, 2'b00, 4'b0000, 1'b0});
    rw_base = rw_cnt;
    run(6'b101011, 6'b000000, 1'b0, "sw");
    chk("sw_no_regwrite", rw_cnt, rw_base);
    run(6'b000010, 6'b000000, 1'b0, "j");
    run(6'b011100, 6'b000010, 1'b0, "mul");
    run(6'b111111, 6'b000000, 1'b0, "bad_op");
    s = hist.size();
    run(6'b000000, 6'b100000, 1'b0, "add_after_bad_op");
    chk("bad_op_pulse_lit", hist[s], {9'b111000000, 2'b01, 2'b00, 4'b0000, 1'b1});
    chk("bad_op_pulse_len", hist[s+1][0], 1'b0);
    run(6'b000000, 6'b111111, 1'b0, "bad_funct");
    run(6'b000010, 6'b000000, 1'b0, "j_after_bad_funct");
    rw_base = rw_cnt;
    opcode = MUL_EN ? 6'b011100 : 6'b100011;
    funct  = 6'b000010;
    zero   = 1'b0;
    repeat (MUL_EN ? 4 : 3) @(posedge clk);
    #2;
    chk("mid_pre", act, MUL_EN ? {9'b000000000, 2'b00, 2'b00, 4'b1000, 1'b0}
                               : {9'b001010000, 2'b00, 2'b00, 4'b0000, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_enables", {pc_write, ir_write, mem_read, mem_write, reg_write}, 5'b0);
    chk("mid_rst_alu", alu_select, 4'b0000);
    chk("mid_rst_state", state, fetch_state);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_release_state", state, fetch_state);
    run(6'b000000, 6'b100000, 1'b0, "add_after_reset");
    chk("mid_no_regwrite", rw_cnt, rw_base + 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 4, giving the number of MUL_WAIT cycles (legal 1..15) for a multiply.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port opcode, input, 6, the instruction-register bits [31:26].
REQ-005 The block SHALL have port funct, input, 6, the instruction-register bits [5:0].
REQ-006 The block SHALL have port zero, input, 1, the ALU Z flag from the current cycle.
REQ-007 The block SHALL have outputs pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg and alu_src_a, each 1 bit and each a datapath control.
REQ-008 The block SHALL have outputs alu_src_b (2 bits: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2) and pc_src (2 bits: 00 = ALU, 01 = ALUOut, 10 = jump target).
REQ-009 The block SHALL have output alu_select, 4 bits, using the ALU codes: add 0000, and 0001, or 0010, nor 0011, slt 0100, sll 0101, srl 0110, sub 0111, mul 1000, lui 1001.
REQ-010 The block SHALL have output illegal, 1 bit, a one-cycle pulse on an unsupported instruction.
REQ-011 The block SHALL have output state, 4 bits, the current state for debug.

Function
REQ-012 The block SHALL be a Moore FSM whose outputs decode from the registered state, except pc_write, which also depends on zero in BRANCH.
REQ-013 The FSM SHALL have states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, MUL_WAIT, R_WB, I_EXEC, I_WB, BRANCH and JUMP.
REQ-014 FETCH SHALL assert mem_read, ir_write and pc_write, with alu_src_a=0, alu_src_b=01, alu_select=add and pc_src=00, then go to DECODE.
REQ-015 DECODE SHALL use alu_src_a=0, alu_src_b=11 and add, then branch on opcode: 100011 or 101011 to MEM_ADR, 000000 to R_EXEC, 011100 (funct 000010) to R_EXEC, 001000, 001100, 001101, 001010 or 001111 to I_EXEC, 000100 or 000101 to BRANCH, 000010 to JUMP, and anything else to FETCH with illegal=1.
REQ-016 R_EXEC SHALL use alu_src_a=1 and alu_src_b=00, and SHALL map funct 100000 to add, 100010 to sub, 100100 to and, 100101 to or, 100111 to nor, 101010 to slt, 000000 to sll and 000010 to srl.
REQ-017 An unknown funct in R_EXEC SHALL return to FETCH with illegal=1 and no register write.
REQ-018 For mul, R_EXEC SHALL drive alu_select=mul, then go to MUL_WAIT and hold alu_select=mul for exactly MULT_CYCLES cycles via a down-counter loaded in R_EXEC, then go to R_WB.
REQ-019 R_WB SHALL assert reg_write and reg_dst=1, hold alu_select at the executed code, then go to FETCH.
REQ-020 I_EXEC SHALL use alu_src_a=1 and alu_src_b=10 with addi mapped to add, andi to and, ori to or, slti to slt and lui to lui; I_WB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0.
REQ-021 MEM_ADR SHALL compute add(A, imm); lw SHALL go to MEM_RD (mem_read, i_or_d=1) then MEM_WB (reg_write, mem_to_reg=1, reg_dst=0); sw SHALL go to MEM_WR (mem_write, i_or_d=1); all three SHALL then return to FETCH.
REQ-022 BRANCH SHALL use alu_src_a=1, alu_src_b=00, sub and pc_src=01, asserting pc_write = zero for beq and ~zero for bne, then go to FETCH.
REQ-023 JUMP SHALL assert pc_write with pc_src=10, then go to FETCH.
REQ-024 The block SHALL have a CPI of 3 for branch and jump, 4 for R-type, I-type and sw, 5 for lw, and 4+MULT_CYCLES for mul.
REQ-025 All outputs not listed for a state SHALL be 0.

Reset
REQ-026 rst_n low SHALL immediately force state=FETCH, clear the mul counter and clear illegal.
REQ-027 While rst_n is low, pc_write, ir_write, mem_read, mem_write and reg_write SHALL be forced to 0, and alu_select SHALL be 0000.
REQ-028 Reset asserted mid-instruction, including mid-MUL_WAIT, SHALL abandon the instruction with no write, and the first cycle after release SHALL be FETCH.

Configuration
REQ-029 With MC_CONTROL_MUL_EN defined, the block SHALL support mul per REQ-018.
REQ-030 With MC_CONTROL_MUL_EN undefined, the block SHALL contain no counter and no MUL_WAIT state, and opcode 011100 SHALL be illegal, returning to FETCH from DECODE with illegal=1.

Verification
REQ-031 Release reset, then apply add (000000 or 100000) -> FETCH, DECODE, R_EXEC(alu_select=0000), R_WB(reg_write=1, reg_dst=1), then FETCH.
REQ-032 beq with zero=1 in BRANCH -> pc_write=1 and pc_src=01; repeat with zero=0 -> pc_write=0; bne -> the opposite.
REQ-033 lw -> 5-cycle sequence with mem_read and i_or_d=1 in MEM_RD and reg_write with mem_to_reg=1 in MEM_WB; sw -> mem_write=1 once, reg_write never asserted.
REQ-034 With MUL_EN and MULT_CYCLES=4, mul -> alu_select=1000 for 5 consecutive cycles (R_EXEC plus 4 MUL_WAIT), then R_WB.
REQ-035 opcode 111111, and separately funct 111111 -> one-cycle illegal pulse, no write enables asserted, next instruction fetched.
REQ-036 rst_n pulsed low during the 2nd MUL_WAIT cycle -> all enables are 0 immediately, FETCH follows release, and no reg_write occurs.
